// File: rtl/output_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : output_collector_if
// Description : Result-capture and host-drain signal bundle for the
//               output collector. The slave modport is the collector itself;
//               the master modport is the controller/host side.
// Revision    : 1.0 - initial release
// ============================================================================
interface output_collector_if #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8
);
    // Result capture from the controller
    logic                             in_valid;
    logic [DATA_WIDTH-1:0]            in_data;
    logic [31:0]                      in_x;
    logic [31:0]                      in_y;
    logic [31:0]                      in_ch;
    logic                             stall;

    // Drain to the host
    logic                             out_valid;
    logic                             out_ready;
    logic [DATA_WIDTH-1:0]            out_data;
    logic [31:0]                      out_x;
    logic [31:0]                      out_y;
    logic [31:0]                      out_ch;

    // Status
    logic [$clog2(FIFO_DEPTH+1)-1:0]  count;
    logic                             overflow;
    logic                             done;

    modport slave (
        input  in_valid, in_data, in_x, in_y, in_ch, out_ready,
        output stall, out_valid, out_data, out_x, out_y, out_ch,
               count, overflow, done
    );

    modport master (
        output in_valid, in_data, in_x, in_y, in_ch, out_ready,
        input  stall, out_valid, out_data, out_x, out_y, out_ch,
               count, overflow, done
    );
endinterface
`default_nettype wire

// File: rtl/output_collector.sv
`default_nettype none
// ============================================================================
// Module      : output_collector
// Description : Captures finished output pixels into a show-ahead circular
//               FIFO, drains them to the host over valid/ready, raises an
//               early stall so in-flight MAC results always have a slot, and
//               pulses done once a full feature map has been drained.
// Revision    : 1.0 - initial release
// ============================================================================
module output_collector #(
    parameter int DATA_WIDTH         = 32,
    parameter int FIFO_DEPTH         = 8,
    parameter int PIPE_SLACK         = 5,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64
) (
    input  wire logic          clk,
    input  wire logic          rst_in,
    output_collector_if.slave  bus
);
    localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int c_TOTAL   = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS;
    localparam int c_DRAIN_W = (c_TOTAL > 1) ? $clog2(c_TOTAL) : 1;

    localparam logic [c_CNT_W-1:0]   c_FULL     = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0]   c_STALL_AT = c_CNT_W'(FIFO_DEPTH - PIPE_SLACK);
    localparam logic [c_DRAIN_W-1:0] c_LAST     = c_DRAIN_W'(c_TOTAL - 1);

    typedef enum logic [0:0] {
        S_COLLECT = 1'b0,
        S_FINISH  = 1'b1
    } state_t;

    // Storage
    logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
    logic [31:0]           r_mem_x    [FIFO_DEPTH];
    logic [31:0]           r_mem_y    [FIFO_DEPTH];
    logic [31:0]           r_mem_ch   [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wptr;
    logic [c_PTR_W-1:0]    r_rptr;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_stall;
    logic                  r_overflow;

    // Completion tracking
    state_t                r_state;
    state_t                w_state_next;
    logic [c_DRAIN_W-1:0]  r_drain;
    logic [c_DRAIN_W-1:0]  w_drain_next;
    logic                  w_done;

    logic                  w_pop;
    logic                  w_full;
    logic                  w_push;
    logic                  w_drop;
    logic [c_CNT_W-1:0]    w_count_next;

    // A pop frees the head slot in the same edge, so a push at full is
    // still accepted when the host takes an entry in that cycle.
    assign w_pop  = (r_count != '0) && bus.out_ready;
    assign w_full = (r_count == c_FULL);
    assign w_push = bus.in_valid && (!w_full || w_pop);
    assign w_drop = bus.in_valid && w_full && !w_pop;

    // Occupancy after this edge; simultaneous push and pop cancel out
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // FIFO storage, pointers, occupancy, early stall and sticky overflow
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_stall    <= 1'b0;
            r_overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_x[i]    <= '0;
                r_mem_y[i]    <= '0;
                r_mem_ch[i]   <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem_data[r_wptr] <= bus.in_data;
                r_mem_x[r_wptr]    <= bus.in_x;
                r_mem_y[r_wptr]    <= bus.in_y;
                r_mem_ch[r_wptr]   <= bus.in_ch;
                r_wptr             <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_next;
            // Stall is taken from the next-state count so it rises the cycle
            // after the push that reaches the threshold.
            r_stall <= (w_count_next >= c_STALL_AT);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Completion FSM state and drain counter registers
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_state <= S_COLLECT;
            r_drain <= '0;
        end else begin
            r_state <= w_state_next;
            r_drain <= w_drain_next;
        end
    end

    // Completion FSM next state; pops during the FINISH cycle already belong
    // to the next map so they are counted there too.
    always_comb begin
        w_state_next = r_state;
        w_drain_next = r_drain;
        w_done       = 1'b0;
        case (r_state)
            S_COLLECT: w_state_next = S_COLLECT;
            S_FINISH: begin
                w_done       = 1'b1;
                w_state_next = S_COLLECT;
            end
            default:   w_state_next = S_COLLECT;
        endcase
        if (w_pop) begin
            if (r_drain == c_LAST) begin
                w_drain_next = '0;
                w_state_next = S_FINISH;
            end else begin
                w_drain_next = r_drain + 1'b1;
            end
        end
    end

    assign bus.out_valid = (r_count != '0);
    assign bus.out_data  = r_mem_data[r_rptr];
    assign bus.out_x     = r_mem_x[r_rptr];
    assign bus.out_y     = r_mem_y[r_rptr];
    assign bus.out_ch    = r_mem_ch[r_rptr];
    assign bus.count     = r_count;
    assign bus.stall     = r_stall;
    assign bus.overflow  = r_overflow;
    assign bus.done      = w_done;

endmodule
`default_nettype wire

// File: tb/tb_output_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_collector
// Description : Directed self-checking bench for output_collector with a
//               2x2x2 feature map (8 results per map).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_collector;
    localparam int c_DW = 32;

    logic clk;
    logic rst_in;
    int   errors;
    int   checks;
    int   pop_cnt;

    output_collector_if #(.DATA_WIDTH(c_DW), .FIFO_DEPTH(8)) bus ();

    output_collector #(
        .DATA_WIDTH         (c_DW),
        .FIFO_DEPTH         (8),
        .PIPE_SLACK         (5),
        .FEATURE_MAP_WIDTH  (2),
        .FEATURE_MAP_HEIGHT (2),
        .OUTPUT_NB_CHANNELS (2)
    ) dut (
        .clk    (clk),
        .rst_in (rst_in),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_in       = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        rst_in  = 1'b0;
        pop_cnt = 0;
    endtask

    task automatic push(input logic [31:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_x     = d ^ 32'h100;
        bus.in_y     = d + 32'd1;
        bus.in_ch    = d + 32'd2;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Host takes one entry (out_ready must already be high); every 8th pop
    // since reset completes a map and must be followed by a done pulse.
    task automatic pop_one(input logic [31:0] d);
        check("pop_valid", 64'(bus.out_valid), 64'd1);
        check("pop_data",  64'(bus.out_data), 64'(d));
        check("pop_x",     64'(bus.out_x), 64'(d ^ 32'h100));
        tick();
        pop_cnt++;
        check("pop_done",  64'(bus.done), 64'((pop_cnt % 8) == 0));
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        pop_cnt       = 0;
        rst_in        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_ch     = '0;
        bus.out_ready = 1'b0;

        // Reset state
        do_reset();
        check("rst_count",    64'(bus.count), 64'd0);
        check("rst_valid",    64'(bus.out_valid), 64'd0);
        check("rst_stall",    64'(bus.stall), 64'd0);
        check("rst_overflow", 64'(bus.overflow), 64'd0);
        check("rst_done",     64'(bus.done), 64'd0);
        check("rst_data",     64'(bus.out_data), 64'd0);

        // Single result with host always ready
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hA5;
        bus.in_x      = 32'd1;
        bus.in_y      = 32'd2;
        bus.in_ch     = 32'd3;
        tick();
        bus.in_valid = 1'b0;
        check("single_valid", 64'(bus.out_valid), 64'd1);
        check("single_data",  64'(bus.out_data), 64'hA5);
        check("single_x",     64'(bus.out_x), 64'd1);
        check("single_y",     64'(bus.out_y), 64'd2);
        check("single_ch",    64'(bus.out_ch), 64'd3);
        check("single_count", 64'(bus.count), 64'd1);
        tick();
        check("single_count_after", 64'(bus.count), 64'd0);
        check("single_valid_after", 64'(bus.out_valid), 64'd0);

        // Backpressure fill, overflow, then in-order drain (8 pops -> done)
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push(32'(i));
            check("bp_count", 64'(bus.count), 64'(i + 1));
            check("bp_stall", 64'(bus.stall), 64'((i + 1) >= 3));
        end
        check("bp_overflow_clear", 64'(bus.overflow), 64'd0);
        push(32'h99);
        check("ovf_set",   64'(bus.overflow), 64'd1);
        check("ovf_count", 64'(bus.count), 64'd8);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pop_one(32'(i));
            check("drain_count", 64'(bus.count), 64'(7 - i));
            check("drain_stall", 64'(bus.stall), 64'((7 - i) >= 3));
        end
        check("drain_empty", 64'(bus.out_valid), 64'd0);
        tick();
        check("done_one_cycle", 64'(bus.done), 64'd0);
        check("ovf_sticky",     64'(bus.overflow), 64'd1);
        do_reset();
        check("ovf_cleared",    64'(bus.overflow), 64'd0);

        // Push and pop together at full, then a second map of 8
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(32'(10 + i));
        check("full_count", 64'(bus.count), 64'd8);
        bus.out_ready = 1'b1;
        push(32'h55);
        pop_cnt++;
        check("pp_count",    64'(bus.count), 64'd8);
        check("pp_overflow", 64'(bus.overflow), 64'd0);
        check("pp_done",     64'(bus.done), 64'd0);
        for (int i = 1; i < 8; i++) pop_one(32'(10 + i));
        pop_one(32'h55);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(32'(20 + i));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) pop_one(32'(20 + i));
        tick();
        check("batch2_done_low", 64'(bus.done), 64'd0);

        // Reset mid-stream clears the buffer and the drain counter
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) push(32'(40 + i));
        bus.out_ready = 1'b1;
        pop_one(32'd40);
        pop_one(32'd41);
        check("mid_count", 64'(bus.count), 64'd5);
        rst_in = 1'b1;
        tick();
        rst_in        = 1'b0;
        bus.out_ready = 1'b0;
        pop_cnt       = 0;
        check("mid_rst_count", 64'(bus.count), 64'd0);
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_stall", 64'(bus.stall), 64'd0);
        for (int i = 0; i < 8; i++) push(32'(30 + i));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) pop_one(32'(30 + i));
        bus.out_ready = 1'b0;
        tick();
        check("mid_done_low", 64'(bus.done), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/output_collector.md
# output_collector

Downstream stage of the convolution controller/datapath: captures each finished output pixel (`output_valid` pulse with `output_x/y/ch` and the MAC result) into a small FIFO and drains it to the host over a valid/ready handshake. It issues an early `stall` to the controller so that results already in the MAC pipeline always have a slot. It also counts drained results and pulses `done` once the full feature map has been delivered.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of one output result
- `FIFO_DEPTH`, 8, entries; power of two, ≥ `PIPE_SLACK`+1
- `PIPE_SLACK`, 5, results that may still arrive after `stall` rises (controller pipeline depth)
- `FEATURE_MAP_WIDTH`, 1024, output x extent
- `FEATURE_MAP_HEIGHT`, 1024, output y extent
- `OUTPUT_NB_CHANNELS`, 64, output channels

Ports:
- `clk` in 1: single clock, all state on rising edge
- `rst_in` in 1: reset, synchronous, active-high
- `in_valid` in 1: one-cycle result strobe from controller
- `in_data` in DATA_WIDTH: result value
- `in_x`, `in_y`, `in_ch` in 32 each: result coordinates
- `stall` out 1: controller must stop issuing MACs
- `out_valid` out 1: head entry available
- `out_ready` in 1: host accepts head entry
- `out_data` out DATA_WIDTH; `out_x`, `out_y`, `out_ch` out 32 each: head entry
- `count` out $clog2(FIFO_DEPTH+1): current occupancy
- `overflow` out 1: sticky, a result was dropped
- `done` out 1: one-cycle pulse after the last result is drained

## Operation
- Storage: circular buffer of {data,x,y,ch}, with write pointer, read pointer, and occupancy counter. Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- Push: `in_valid` && `count` < FIFO_DEPTH writes at wptr, then wptr+1.
- Push when full (`count`==FIFO_DEPTH and no pop in the same cycle): entry dropped, `overflow` set; it stays set until reset.
- Pop: `out_valid` && `out_ready` advances rptr.
- Simultaneous push and pop:
  - Both take effect and `count` is unchanged.
  - At full with a pop, the push is accepted and there is no overflow.
  - At empty, only the push occurs; there is no bypass.
- Output is show-ahead: `out_valid` = (`count` != 0); `out_*` is driven from the entry at rptr.
- `out_*` holds stable while `out_valid` && !`out_ready`.
- `stall` = (`count` ≥ FIFO_DEPTH − PIPE_SLACK), registered from the next-state count.
- Completion FSM, states COLLECT and FINISH:
  - COLLECT: a drain counter (width $clog2(W·H·CH)) increments on each pop.
  - On the pop taking the counter to W·H·CH: counter clears, go to FINISH.
  - FINISH: `done`=1 for one cycle, then return to COLLECT unconditionally. The next map then starts counting from 0.
- Coordinates pass through untouched; no range checks.

## Timing
- Reset values: `count`=0, pointers=0, `out_valid`=0, `stall`=0, `overflow`=0, `done`=0, FSM=COLLECT, drain counter=0. `out_*` data outputs are don't-care while `out_valid`=0; they drive 0 after reset.
- Reset mid-operation discards all buffered entries; no output handshake completes in the reset cycle.
- Latency: `in_valid` at edge n gives `out_valid`=1 in cycle n+1.
- `stall` rises in the cycle after the push that reaches the threshold. With default params the threshold is `count` ≥ 3, leaving 5 free slots for in-flight results.
- `done` is asserted in the cycle after the final pop handshake.
- Host may hold `out_ready` high constantly: throughput is one result per cycle.

## Test plan
- Single result, `out_ready`=1: push {data=0xA5, x=1, y=2, ch=3} → `out_valid`=1 the next cycle with the same fields, `count` 1→0.
- Backpressure, `out_ready`=0, 8 pushes with data 0..7: `stall` high after the 3rd push, `count`=8, no `overflow`. Then `out_ready`=1 → data 0..7 out in order, `stall` falls when `count`<3.
- Overflow: full FIFO, `out_ready`=0, one more push → `overflow`=1, `count`=8, dropped value never appears. `overflow` stays 1 until `rst_in`.
- Push+pop at full: `count`=8 with `out_ready`=1 and `in_valid`=1 → `count` stays 8, `overflow`=0, new entry emerges 8th.
- Completion with W=H=2, CH=2: drain 8 results → single-cycle `done` after the 8th handshake. A second batch of 8 gives a second `done`.
- Reset mid-stream: 5 entries buffered, `rst_in` for 1 cycle → `count`=0, `out_valid`=0, `stall`=0, drain counter 0. A subsequent 8-result map (W=H=CH=2) still yields `done` exactly after 8 pops.
